imem_fetch_port: RTL and testbench

//  Parametrised, clocked instruction memory for the RV64 pipeline IF stage.
//  - Word-organised, byte-addressed storage with a registered (1-cycle) read.
//  - Valid/ready request and response handshake, so IF can stall.
//  - Flush input discards an in-flight fetch on a taken branch or jump.
//  - Alignment/range fault reporting; optional program-load write port.

---
 rtl/imem_pkg.sv | 27 ++
 rtl/imem_array.sv | 51 +++++
 rtl/imem_fetch_port.sv | 102 ++++++++++
 tb/tb_imem_fetch_port.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared constants and helpers for the instruction-memory fetch port.
package imem_pkg;

    localparam logic [31:0] IMEM_NOP = 32'h00000013;

    // rsp_fault bit positions
    localparam int unsigned FAULT_MISALIGN = 0;
    localparam int unsigned FAULT_RANGE    = 1;

    // Width of the word index for a memory of the given depth
    function automatic int unsigned imem_idx_w(input int unsigned depth_words);
        return $clog2(depth_words);
    endfunction

    // Boot program image; words not listed take the fill value
    function automatic logic [31:0] imem_prog_word(input int unsigned idx, input logic [31:0] fill);
        case (idx)
            0:       return 32'h00A00093; // addi x1, x0, 10
            1:       return 32'h01400113; // addi x2, x0, 20
            2:       return 32'h002081B3; // add  x3, x1, x2
            3:       return 32'h40208233; // sub  x4, x1, x2
            4:       return 32'h0041A023; // sw   x4, 0(x3)
            default: return fill;
        endcase
    endfunction

endpackage

// File: rtl/imem_array.sv
// DEPTH_WORDS x 32 instruction storage: one registered read port, one write port.
// Contents come from the boot image at elaboration and are never reset.
module imem_array
    import imem_pkg::*;
#(
    parameter  int unsigned DEPTH_WORDS = 32,
    parameter  logic [31:0] INIT_WORD   = IMEM_NOP,
    localparam int unsigned IW          = imem_idx_w(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rd_en,
    input  logic [IW-1:0] rd_idx,
    output logic [31:0]   rd_data,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  logic [31:0]   wr_data
);

    typedef logic [31:0] mem_t [DEPTH_WORDS];

    function automatic mem_t f_image();
        mem_t m;
        for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
            m[i] = imem_prog_word(i, INIT_WORD);
        end
        return m;
    endfunction

    mem_t        r_mem = f_image();
    logic [31:0] r_rd_data;

    // Word write; a same-cycle read of this word still sees the old value
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_idx] <= wr_data;
        end
    end

    // Registered read, updated only when a fetch is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= INIT_WORD;
        end else if (rd_en) begin
            r_rd_data <= r_mem[rd_idx];
        end
    end

    assign rd_data = r_rd_data;

endmodule

// File: rtl/imem_fetch_port.sv
// IF-stage instruction memory port: valid/ready handshake, flush, fault reporting.
// Optional program-load write port enabled by defining IMEM_LOAD_EN.
module imem_fetch_port
    import imem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 64,
    parameter int unsigned DEPTH_WORDS = 32,
    parameter logic [31:0] INIT_WORD   = IMEM_NOP
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              flush,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_instr,
    output logic [1:0]        rsp_fault
`ifdef IMEM_LOAD_EN
    ,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_data
`endif
);

    localparam int unsigned IW = imem_idx_w(DEPTH_WORDS);

    // Fault bits for a byte address; range test by shift avoids an empty slice
    function automatic logic [1:0] f_fault(input logic [ADDR_W-1:0] a);
        logic [1:0] f;
        f                 = '0;
        f[FAULT_MISALIGN] = |a[1:0];
        f[FAULT_RANGE]    = (a >> (IW + 2)) != '0;
        return f;
    endfunction

    logic          w_accept;
    logic [1:0]    w_req_fault;
    logic [31:0]   w_rd_data;
    logic          w_ld_en;
    logic [IW-1:0] w_ld_idx;
    logic [31:0]   w_ld_data;
    logic          r_rsp_valid;
    logic [1:0]    r_fault;

    assign req_ready   = !flush && (!r_rsp_valid || rsp_ready);
    assign w_accept    = req_valid && req_ready;
    assign w_req_fault = f_fault(req_addr);

`ifdef IMEM_LOAD_EN
    assign w_ld_en   = ld_we && (f_fault(ld_addr) == '0);
    assign w_ld_idx  = ld_addr[IW+1:2];
    assign w_ld_data = ld_data;
`else
    assign w_ld_en   = 1'b0;
    assign w_ld_idx  = '0;
    assign w_ld_data = '0;
`endif

    // Response valid: flush wins, then a new accept, then consumption clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
        end else if (flush) begin
            r_rsp_valid <= 1'b0;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    // Fault status captured alongside the read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fault <= '0;
        end else if (w_accept) begin
            r_fault <= w_req_fault;
        end
    end

    imem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .INIT_WORD   (INIT_WORD)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_en   (w_accept),
        .rd_idx  (req_addr[IW+1:2]),
        .rd_data (w_rd_data),
        .wr_en   (w_ld_en),
        .wr_idx  (w_ld_idx),
        .wr_data (w_ld_data)
    );

    assign rsp_valid = r_rsp_valid;
    assign rsp_fault = r_fault;
    assign rsp_instr = (r_fault != '0) ? INIT_WORD : w_rd_data;

endmodule

// File: tb/tb_imem_fetch_port.sv
// Self-checking bench for imem_fetch_port (ld_* exercised when IMEM_LOAD_EN is defined).
module tb_imem_fetch_port;

    localparam int unsigned DEPTH = 32;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        flush;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic [1:0]  rsp_fault;
`ifdef IMEM_LOAD_EN
    logic        ld_we;
    logic [63:0] ld_addr;
    logic [31:0] ld_data;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    imem_fetch_port #(
        .ADDR_W      (64),
        .DEPTH_WORDS (DEPTH),
        .INIT_WORD   (NOP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .flush     (flush),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_fault (rsp_fault)
`ifdef IMEM_LOAD_EN
        ,
        .ld_we     (ld_we),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] instr;
        logic [1:0]  fault;
    } rsp_t;

    logic [31:0] model_mem [DEPTH];
    rsp_t        exp_q [$];

    initial begin
        for (int i = 0; i < DEPTH; i++) model_mem[i] = NOP;
        model_mem[0] = 32'h00A00093;
        model_mem[1] = 32'h01400113;
        model_mem[2] = 32'h002081B3;
        model_mem[3] = 32'h40208233;
        model_mem[4] = 32'h0041A023;
    end

    function automatic rsp_t model_read(input logic [63:0] a);
        rsp_t r;
        r.fault[0] = (a % 4) != 0;
        r.fault[1] = a >= 64'(DEPTH * 4);
        r.instr    = (r.fault != 2'b00) ? NOP : model_mem[a / 4];
        return r;
    endfunction

    // The queue head is the response currently on offer
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            bit   can_take;
            bit   taken;
            rsp_t r;
            can_take = !flush && (exp_q.size() == 0 || rsp_ready);
            taken    = req_valid && can_take;
            r        = model_read(req_addr);
            if (flush || (exp_q.size() != 0 && rsp_ready)) exp_q.delete();
            if (taken) exp_q.push_back(r);
`ifdef IMEM_LOAD_EN
            if (ld_we && (ld_addr % 4) == 0 && ld_addr < 64'(DEPTH * 4))
                model_mem[ld_addr / 4] = ld_data;
`endif
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        chk("rsp_valid", 64'(rsp_valid), 64'(exp_q.size() != 0));
        if (rst_n) begin
            chk("req_ready", 64'(req_ready), 64'(!flush && (exp_q.size() == 0 || rsp_ready)));
            if (exp_q.size() != 0) begin
                chk("rsp_instr", 64'(rsp_instr), 64'(exp_q[0].instr));
                chk("rsp_fault", 64'(rsp_fault), 64'(exp_q[0].fault));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        flush     = 1'b0;
        rsp_ready = 1'b0;
`ifdef IMEM_LOAD_EN
        ld_we   = 1'b0;
        ld_addr = '0;
        ld_data = '0;
`endif
        step();
        step();
        chk("reset_valid", 64'(rsp_valid), 64'(0));
        chk("reset_instr", 64'(rsp_instr), 64'(NOP));
        chk("reset_fault", 64'(rsp_fault), 64'(0));
        rst_n = 1'b1;
        step();

        // back-to-back fetches
        req_valid = 1'b1; req_addr = 64'h00; rsp_ready = 1'b1;
        step();
        chk("b2b_first", 64'(rsp_instr), 64'h00A00093);
        chk("b2b_first_v", 64'(rsp_valid), 64'(1));
        req_addr = 64'h04;
        step();
        chk("b2b_second", 64'(rsp_instr), 64'h01400113);
        chk("b2b_second_v", 64'(rsp_valid), 64'(1));
        req_valid = 1'b0;
        step();
        chk("b2b_drain", 64'(rsp_valid), 64'(0));

        // stall for 3 cycles
        req_valid = 1'b1; req_addr = 64'h08; rsp_ready = 1'b0;
        step();
        req_addr = 64'h0C;
        for (int i = 0; i < 3; i++) begin
            chk("stall_instr", 64'(rsp_instr), 64'h002081B3);
            chk("stall_ready", 64'(req_ready), 64'(0));
            step();
        end
        rsp_ready = 1'b1;
        #1;
        chk("release_ready", 64'(req_ready), 64'(1));
        step();
        chk("after_stall", 64'(rsp_instr), 64'h40208233);

        // flush in the response cycle of 0x0C
        flush = 1'b1; req_addr = 64'h10;
        #1;
        chk("flush_ready", 64'(req_ready), 64'(0));
        step();
        flush = 1'b0; req_valid = 1'b0;
        chk("flush_valid", 64'(rsp_valid), 64'(0));
        step();
        chk("flush_noaccept", 64'(rsp_valid), 64'(0));

        // faults
        req_valid = 1'b1; req_addr = 64'h06;
        step();
        chk("mis_fault", 64'(rsp_fault), 64'(2'b01));
        chk("mis_instr", 64'(rsp_instr), 64'(NOP));
        req_addr = 64'h80;
        step();
        chk("rng_fault", 64'(rsp_fault), 64'(2'b10));
        chk("rng_instr", 64'(rsp_instr), 64'(NOP));
        req_addr = 64'h8000_0000_0000_0083;
        step();
        chk("both_fault", 64'(rsp_fault), 64'(2'b11));
        req_addr = 64'h7C;
        step();
        chk("last_word", 64'(rsp_instr), 64'(NOP));
        chk("last_fault", 64'(rsp_fault), 64'(0));
        req_valid = 1'b0;
        step();

`ifdef IMEM_LOAD_EN
        // read-during-write returns the old word
        ld_we = 1'b1; ld_addr = 64'h10; ld_data = 32'hDEADBEEF;
        req_valid = 1'b1; req_addr = 64'h10;
        step();
        ld_we = 1'b0;
        chk("rdw_old", 64'(rsp_instr), 64'h0041A023);
        step();
        chk("rdw_new", 64'(rsp_instr), 64'hDEADBEEF);
        // misaligned and out-of-range loads are dropped
        ld_we = 1'b1; ld_addr = 64'h16; ld_data = 32'h11111111;
        req_valid = 1'b0;
        step();
        ld_addr = 64'h94;
        step();
        ld_we = 1'b0;
        req_valid = 1'b1; req_addr = 64'h14;
        step();
        chk("ld_mis_ignored", 64'(rsp_instr), 64'(NOP));
        req_valid = 1'b0;
        step();
`endif

        // asynchronous reset while stalled
        req_valid = 1'b1; req_addr = 64'h00; rsp_ready = 1'b0;
        step();
        req_valid = 1'b0;
        step();
        chk("pre_reset_valid", 64'(rsp_valid), 64'(1));
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_valid", 64'(rsp_valid), 64'(0));
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("post_reset_valid", 64'(rsp_valid), 64'(0));
        rsp_ready = 1'b1;
        step();
        chk("post_reset_idle", 64'(rsp_valid), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
